axi_write_mem_bridge: RTL

AXI4 write-only slave that terminates the 128-bit master side of the 32→128 write upsizer and drives a single-port SRAM-style write interface.
- Accepts one AW burst at a time (FIXED/INCR/WRAP, full or narrow size).
- Converts each W beat into one memory write request with a byte enable.
- Returns one B response per burst.
- Sits directly downstream of the upsizer and replaces the random-ready stub on the 128-bit bus.

---
 rtl/axi_size_conv_pkg.sv | 50 +++++
 rtl/axi_burst_addr_gen.sv | 50 +++++
 rtl/axi_write_mem_bridge.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/axi_size_conv_pkg.sv
// rtl/axi_size_conv_pkg.sv - shared AXI burst types, response codes and next-address helper
package axi_size_conv_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_t;

    // Address math is done at this width; callers zero-extend and truncate.
    localparam int ADDR_CALC_W = 64;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [ADDR_CALC_W-1:0] axi_next_addr(
        input logic [ADDR_CALC_W-1:0] addr,
        input logic [2:0]             size,
        input logic [7:0]             len,
        input burst_t                 burst
    );
        logic [ADDR_CALC_W-1:0] incr;
        logic [ADDR_CALC_W-1:0] aligned;
        logic [ADDR_CALC_W-1:0] wrap_mask;
        logic [ADDR_CALC_W-1:0] result;
        incr      = ADDR_CALC_W'(1) << size;
        aligned   = addr & ~(incr - ADDR_CALC_W'(1));
        wrap_mask = (ADDR_CALC_W'({1'b0, len} + 9'd1) << size) - ADDR_CALC_W'(1);
        result    = aligned + incr;
        if (burst == BURST_FIXED) begin
            result = addr;
        end else if (burst == BURST_WRAP && wrap_len_ok(len)) begin
            result = (addr & ~wrap_mask) | ((aligned + incr) & wrap_mask);
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - latched AXI burst descriptor and current beat address
module axi_burst_addr_gen
    import axi_size_conv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic [7:0]        o_len,
    output logic              o_burst_err
);

    logic [ADDR_W-1:0] r_cur_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    burst_t            r_burst;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_next_addr = ADDR_W'(axi_next_addr(ADDR_CALC_W'(r_cur_addr), r_size, r_len, r_burst));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cur_addr <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= BURST_FIXED;
        end else if (i_load) begin
            r_cur_addr <= i_addr;
            r_len      <= i_len;
            r_size     <= i_size;
            r_burst    <= burst_t'(i_burst);
        end else if (i_advance) begin
            r_cur_addr <= w_next_addr;
        end
    end

    // Illegal wrap lengths and the reserved encoding still walk as INCR, but get flagged.
    assign o_burst_err = (r_burst == BURST_RSVD) ||
                         ((r_burst == BURST_WRAP) && !wrap_len_ok(r_len));
    assign o_cur_addr  = r_cur_addr;
    assign o_len       = r_len;

endmodule

// File: rtl/axi_write_mem_bridge.sv
// rtl/axi_write_mem_bridge.sv - AXI4 write slave driving a single-port SRAM write interface
module axi_write_mem_bridge
    import axi_size_conv_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 128,
    parameter int                        AXI_ID_WIDTH   = 5,
    parameter int                        AXI_USER_WIDTH = 6,
    parameter int                        MEM_ADDR_WIDTH = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        axi_slave_aw_valid_i,
    output logic                        axi_slave_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr_i,
    input  logic [7:0]                  axi_slave_aw_len_i,
    input  logic [2:0]                  axi_slave_aw_size_i,
    input  logic [1:0]                  axi_slave_aw_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id_i,
    input  logic [2:0]                  axi_slave_aw_prot_i,
    input  logic [3:0]                  axi_slave_aw_region_i,
    input  logic                        axi_slave_aw_lock_i,
    input  logic [3:0]                  axi_slave_aw_cache_i,
    input  logic [3:0]                  axi_slave_aw_qos_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user_i,
    input  logic                        axi_slave_w_valid_i,
    output logic                        axi_slave_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb_i,
    input  logic                        axi_slave_w_last_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user_i,
    output logic                        axi_slave_b_valid_o,
    input  logic                        axi_slave_b_ready_i,
    output logic [1:0]                  axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user_o,
    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o
);

    localparam int STRB     = AXI_DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB);
    localparam int WIN_BITS = MEM_ADDR_WIDTH + OFF_BITS;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [7:0]                r_beat;
    logic                      r_decerr;
    logic                      r_slverr;
    logic                      w_aw_fire;
    logic                      w_w_fire;
    logic                      w_last_beat;
    logic                      w_in_range;
    logic                      w_burst_err;
    logic [7:0]                w_len;
    logic [AXI_ADDR_WIDTH-1:0] w_aw_offset;
    logic [AXI_ADDR_WIDTH-1:0] w_cur_addr;
    logic [AXI_ADDR_WIDTH-1:0] w_cur_offset;
    logic                      w_unused_ok;

    axi_burst_addr_gen #(
        .ADDR_W (AXI_ADDR_WIDTH)
    ) u_addr_gen (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_load      (w_aw_fire),
        .i_addr      (axi_slave_aw_addr_i),
        .i_len       (axi_slave_aw_len_i),
        .i_size      (axi_slave_aw_size_i),
        .i_burst     (axi_slave_aw_burst_i),
        .i_advance   (w_w_fire),
        .o_cur_addr  (w_cur_addr),
        .o_len       (w_len),
        .o_burst_err (w_burst_err)
    );

    // Offset subtraction wraps modulo the address width, so addresses below BASE land far out of range.
    assign w_aw_offset  = axi_slave_aw_addr_i - BASE_ADDR;
    assign w_in_range   = (64'(w_aw_offset) < (64'd1 << WIN_BITS));
    assign w_cur_offset = w_cur_addr - BASE_ADDR;

    assign axi_slave_aw_ready_o = (r_state == ST_IDLE) && !rst_i;
    assign w_aw_fire            = axi_slave_aw_valid_i && axi_slave_aw_ready_o;
    assign axi_slave_w_ready_o  = (r_state == ST_DATA) && (r_decerr || mem_gnt_i);
    assign w_w_fire             = axi_slave_w_valid_i && axi_slave_w_ready_o;
    assign w_last_beat          = (r_beat == w_len);

    assign mem_req_o   = (r_state == ST_DATA) && !r_decerr && axi_slave_w_valid_i;
    assign mem_addr_o  = ((r_state == ST_DATA) && !r_decerr) ?
                         MEM_ADDR_WIDTH'(w_cur_offset >> OFF_BITS) : '0;
    assign mem_wdata_o = axi_slave_w_data_i;
    assign mem_be_o    = axi_slave_w_strb_i;

    assign axi_slave_b_valid_o = (r_state == ST_RESP);
    assign axi_slave_b_resp_o  = (r_state != ST_RESP)          ? RESP_OKAY   :
                                 r_decerr                      ? RESP_DECERR :
                                 (r_slverr || w_burst_err)     ? RESP_SLVERR : RESP_OKAY;
    assign axi_slave_b_id_o    = r_id;
    assign axi_slave_b_user_o  = '0;

    assign w_unused_ok = ^{axi_slave_aw_prot_i, axi_slave_aw_region_i, axi_slave_aw_lock_i,
                           axi_slave_aw_cache_i, axi_slave_aw_qos_i, axi_slave_aw_user_i,
                           axi_slave_w_user_i};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_aw_fire)                 w_state_next = ST_DATA;
            ST_DATA: if (w_w_fire && w_last_beat)   w_state_next = ST_RESP;
            ST_RESP: if (axi_slave_b_ready_i)       w_state_next = ST_IDLE;
            default:                                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_id     <= '0;
            r_beat   <= '0;
            r_decerr <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_aw_fire) begin
                r_id     <= axi_slave_aw_id_i;
                r_beat   <= '0;
                r_decerr <= !w_in_range;
                r_slverr <= 1'b0;
            end else if (w_w_fire) begin
                // The beat counter alone ends the burst; a misplaced w_last only flags an error.
                if (axi_slave_w_last_i != w_last_beat) r_slverr <= 1'b1;
                if (!w_last_beat)                      r_beat   <= r_beat + 8'd1;
            end
        end
    end

endmodule
